sobel_sequencer: RTL and testbench
==================================

# sobel_sequencer

Parametrised control sequencer for the Sobel edge-detection datapath. It walks a KSIZE×KSIZE window across an IMG_W×IMG_H image and issues one-cycle start pulses to the read, shift, calculation and write units, waiting on each unit's done handshake. It generates the pixel read coordinates and the output coordinates. After the first window of a row it reuses the window by sliding one column and reading only the new column. It sits between the top-level start/status interface and the pixel buffer, gradient and write-back units.

## Interface
- IMG_W, 640: image width in pixels; must be ≥ KSIZE.
- IMG_H, 480: image height in pixels; must be ≥ KSIZE.
- KSIZE, 3: window edge; must be odd and ≥ 3.
- CW, 10: coordinate width; must satisfy 2^CW ≥ max(IMG_W, IMG_H).
- clk  in  1  clock, rising edge.
- n_rst  in  1  reset; asynchronous, active-low.
- start  in  1  begin an image; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE next cycle from any state.
- read_done, shift_done, calc_done, write_done  in  1 each  unit completion strobes.
- start_read, start_shift, start_calc, start_write  out  1 each  one-cycle request pulses.
- rd_x, rd_y  out  CW each  pixel address; valid in the start_read pulse cycle.
- out_x, out_y  out  CW each  centre-offset output coordinate (window top-left); valid in the start_write pulse cycle.
- busy  out  1  high in every state except IDLE.
- image_done  out  1  one-cycle pulse when the last output has been written.

## Operation
- States: IDLE, LOAD_ISSUE, LOAD_WAIT, CALC_ISSUE, CALC_WAIT, WR_ISSUE, WR_WAIT, ADVANCE, SHIFT_ISSUE, SHIFT_WAIT, COL_ISSUE, COL_WAIT, DONE.
- Window position ranges:
  - out_x runs 0..IMG_W−KSIZE; out_y runs 0..IMG_H−KSIZE.
  - Internal counters r, c run 0..KSIZE−1.
- IDLE:
  - On start=1, clear out_x, out_y, r and c, then go to LOAD_ISSUE.
- LOAD_ISSUE/LOAD_WAIT (full window):
  - Pulse start_read with rd_y=out_y+r and rd_x=out_x+c. Order is row-major (c fastest).
  - On read_done, step the counters. After the KSIZE² read, go to CALC_ISSUE; otherwise return to LOAD_ISSUE.
- CALC_ISSUE/CALC_WAIT:
  - Pulse start_calc, then wait for calc_done and go to WR_ISSUE.
- WR_ISSUE/WR_WAIT:
  - Pulse start_write, then wait for write_done and go to ADVANCE.
- ADVANCE has three outcomes:
  - Not the last column: out_x+1, then SHIFT_ISSUE.
  - Last column, not the last row: out_x=0 and out_y+1, then LOAD_ISSUE (full reload).
  - Last column and last row: go to DONE.
- SHIFT_ISSUE/SHIFT_WAIT:
  - Pulse start_shift, wait for shift_done, clear r, then go to COL_ISSUE.
- COL_ISSUE/COL_WAIT (new column):
  - Pulse start_read with rd_x=out_x+KSIZE−1 and rd_y=out_y+r.
  - On read_done, r+1. After KSIZE reads, go to CALC_ISSUE.
- DONE:
  - Pulse image_done for one cycle, then go to IDLE.
- abort has priority over every transition. It forces IDLE and clears the counters; no pulse is issued in that cycle.
- start while busy is ignored.
- Done strobes arriving in IDLE, in ISSUE states, or for a non-waited unit are ignored.
- Arithmetic: all coordinates are unsigned CW-bit values. Sums never exceed IMG_W−1 or IMG_H−1 by construction, so no wrap-around occurs.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- start is registered: LOAD_ISSUE is entered on the edge where start=1, so the first start_read appears one cycle after start.
- Each request pulse lasts exactly one cycle, the ISSUE-state cycle. The done strobe is sampled from the next cycle onward.
- With done returned the cycle after each pulse, every operation takes 2 cycles.
- ADVANCE takes 1 cycle, and DONE takes 1 cycle.
- busy rises together with the first start_read cycle. It falls the cycle after image_done.
- Reset mid-operation: outputs drop to 0 immediately (asynchronous). A pending done from before reset is ignored.
- The datapath holds a done strobe for one cycle. A strobe held longer than one cycle counts only once, because the FSM leaves the WAIT state.

## Test plan
- Reset: assert n_rst=0 mid-LOAD_WAIT → all outputs 0 and busy=0; with start=0 after release, the block stays IDLE.
- Full image, IMG_W=5, IMG_H=4, KSIZE=3, 1-cycle responders → exact pulse counts:
  - 30 start_read (2×(9+2×3)), 4 start_shift, 6 start_calc, 6 start_write.
  - out_x,out_y sequence is (0,0)(1,0)(2,0)(0,1)(1,1)(2,1).
  - One image_done pulse, then busy=0.
- Address order: first window → rd_x,rd_y = (0,0)(1,0)(2,0)(0,1)…(2,2); after the first shift → (3,0)(3,1)(3,2).
- Back-pressure: delay each done by a random 0–7 cycles → same pulse sequence; no extra pulses while waiting; a done in the ISSUE cycle is ignored.
- Abort: assert abort in CALC_WAIT → IDLE next cycle with busy=0 and no start_write; a new start restarts at rd=(0,0).
- Minimum image, IMG_W=IMG_H=KSIZE=3 → 9 reads, 0 shifts, 1 calc, 1 write at out=(0,0), then image_done.

Source files
------------

// File: rtl/sobel_sequencer.sv
// Control sequencer for the Sobel datapath: walks a KSIZE x KSIZE window
// over the image, reusing the window by shifting one column where possible.
module sobel_sequencer #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int KSIZE = 3,
    parameter int CW    = 10
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic          abort,
    input  logic          read_done,
    input  logic          shift_done,
    input  logic          calc_done,
    input  logic          write_done,
    output logic          start_read,
    output logic          start_shift,
    output logic          start_calc,
    output logic          start_write,
    output logic [CW-1:0] rd_x,
    output logic [CW-1:0] rd_y,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic          busy,
    output logic          image_done
);

    typedef enum logic [3:0] {
        IDLE, LOAD_ISSUE, LOAD_WAIT, CALC_ISSUE, CALC_WAIT,
        WR_ISSUE, WR_WAIT, ADVANCE, SHIFT_ISSUE, SHIFT_WAIT,
        COL_ISSUE, COL_WAIT, DONE
    } state_t;

    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] KM1  = CW'(KSIZE - 1);
    localparam logic [CW-1:0] XMAX = CW'(IMG_W - KSIZE);
    localparam logic [CW-1:0] YMAX = CW'(IMG_H - KSIZE);

    state_t        state_q, state_d;
    logic [CW-1:0] ox_q, ox_d;
    logic [CW-1:0] oy_q, oy_d;
    logic [CW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            ox_q    <= '0;
            oy_q    <= '0;
            r_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            r_q     <= r_d;
            c_q     <= c_d;
        end
    end

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        r_d         = r_q;
        c_d         = c_q;
        start_read  = 1'b0;
        start_shift = 1'b0;
        start_calc  = 1'b0;
        start_write = 1'b0;
        rd_x        = '0;
        rd_y        = '0;
        out_x       = '0;
        out_y       = '0;
        image_done  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            ox_d    = '0;
            oy_d    = '0;
            r_d     = '0;
            c_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        ox_d    = '0;
                        oy_d    = '0;
                        r_d     = '0;
                        c_d     = '0;
                        state_d = LOAD_ISSUE;
                    end
                end
                LOAD_ISSUE: begin
                    start_read = 1'b1;
                    rd_x       = ox_q + c_q;
                    rd_y       = oy_q + r_q;
                    state_d    = LOAD_WAIT;
                end
                LOAD_WAIT: begin
                    if (read_done) begin
                        state_d = LOAD_ISSUE;
                        if (c_q == KM1) begin
                            c_d = '0;
                            if (r_q == KM1) begin
                                r_d     = '0;
                                state_d = CALC_ISSUE;
                            end else begin
                                r_d = r_q + ONE;
                            end
                        end else begin
                            c_d = c_q + ONE;
                        end
                    end
                end
                CALC_ISSUE: begin
                    start_calc = 1'b1;
                    state_d    = CALC_WAIT;
                end
                CALC_WAIT: if (calc_done) state_d = WR_ISSUE;
                WR_ISSUE: begin
                    start_write = 1'b1;
                    out_x       = ox_q;
                    out_y       = oy_q;
                    state_d     = WR_WAIT;
                end
                WR_WAIT: if (write_done) state_d = ADVANCE;
                ADVANCE: begin
                    if (ox_q != XMAX) begin
                        ox_d    = ox_q + ONE;
                        state_d = SHIFT_ISSUE;
                    end else if (oy_q != YMAX) begin
                        ox_d    = '0;
                        oy_d    = oy_q + ONE;
                        r_d     = '0;
                        c_d     = '0;
                        state_d = LOAD_ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
                SHIFT_ISSUE: begin
                    start_shift = 1'b1;
                    state_d     = SHIFT_WAIT;
                end
                SHIFT_WAIT: begin
                    if (shift_done) begin
                        r_d     = '0;
                        state_d = COL_ISSUE;
                    end
                end
                // Only the column entering on the right is fetched.
                COL_ISSUE: begin
                    start_read = 1'b1;
                    rd_x       = ox_q + KM1;
                    rd_y       = oy_q + r_q;
                    state_d    = COL_WAIT;
                end
                COL_WAIT: begin
                    if (read_done) begin
                        if (r_q == KM1) begin
                            r_d     = '0;
                            state_d = CALC_ISSUE;
                        end else begin
                            r_d     = r_q + ONE;
                            state_d = COL_ISSUE;
                        end
                    end
                end
                DONE: begin
                    image_done = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_sequencer.sv
// Scoreboard bench for sobel_sequencer: a 5x4 image instance with
// delayed responders and a minimum 3x3 instance with 1-cycle responders.
module tb_sobel_sequencer;

    localparam int CW = 10;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [3:0] dn = '0;
    logic start_read, start_shift, start_calc, start_write;
    logic [CW-1:0] rd_x, rd_y, out_x, out_y;
    logic busy, image_done;

    logic start_m = 1'b0;
    logic abort_m = 1'b0;
    logic [3:0] dm = '0;
    logic [3:0] pm_last = '0;
    logic sr_m, ss_m, sc_m, sw_m;
    logic [CW-1:0] rdx_m, rdy_m, ox_m, oy_m;
    logic busy_m, done_m;

    always #5 clk = ~clk;

    sobel_sequencer #(.IMG_W(5), .IMG_H(4), .KSIZE(3), .CW(CW)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .read_done(dn[0]), .shift_done(dn[1]),
        .calc_done(dn[2]), .write_done(dn[3]),
        .start_read(start_read), .start_shift(start_shift),
        .start_calc(start_calc), .start_write(start_write),
        .rd_x(rd_x), .rd_y(rd_y), .out_x(out_x), .out_y(out_y),
        .busy(busy), .image_done(image_done)
    );

    sobel_sequencer #(.IMG_W(3), .IMG_H(3), .KSIZE(3), .CW(CW)) dut_m (
        .clk(clk), .n_rst(n_rst), .start(start_m), .abort(abort_m),
        .read_done(dm[0]), .shift_done(dm[1]),
        .calc_done(dm[2]), .write_done(dm[3]),
        .start_read(sr_m), .start_shift(ss_m),
        .start_calc(sc_m), .start_write(sw_m),
        .rd_x(rdx_m), .rd_y(rdy_m), .out_x(ox_m), .out_y(oy_m),
        .busy(busy_m), .image_done(done_m)
    );

    typedef struct { int x; int y; } xy_t;
    xy_t exp_rd[$];
    xy_t exp_wr[$];

    int errs = 0;
    int checks = 0;
    int n_rd, n_sh, n_calc, n_wr, n_done;
    int m_rd, m_sh, m_calc, m_wr, m_done;
    bit rnd = 0;
    bit glitch = 0;
    int cnt[4] = '{-1, -1, -1, -1};

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_window(input int ox, input int oy);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                exp_rd.push_back('{ox + c, oy + r});
    endtask

    task automatic push_image(input int w, input int h);
        for (int oy = 0; oy <= h - 3; oy++)
            for (int ox = 0; ox <= w - 3; ox++) begin
                if (ox == 0) push_window(ox, oy);
                else for (int r = 0; r < 3; r++)
                    exp_rd.push_back('{ox + 2, oy + r});
                exp_wr.push_back('{ox, oy});
            end
    endtask

    task automatic clear_counts();
        n_rd = 0; n_sh = 0; n_calc = 0; n_wr = 0; n_done = 0;
    endtask

    task automatic run_start();
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk);
        check("busy_before_first_read", busy, 0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("busy_with_first_read", busy, 1);
        check("first_read_pulse", start_read, 1);
    endtask

    task automatic wait_image(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (image_done) seen = 1;
        end
        check("image_done_timeout", seen, 1);
        check("busy_at_image_done", busy, 1);
        @(negedge clk);
        check("busy_after_image_done", busy, 0);
    endtask

    // Monitor / scoreboard
    initial forever begin
        xy_t e;
        @(negedge clk);
        if (start_read) begin
            n_rd++;
            check("read_expected", exp_rd.size() > 0, 1);
            if (exp_rd.size() > 0) begin
                e = exp_rd.pop_front();
                check("rd_x", rd_x, e.x);
                check("rd_y", rd_y, e.y);
            end
        end
        if (start_write) begin
            n_wr++;
            check("write_expected", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) begin
                e = exp_wr.pop_front();
                check("out_x", out_x, e.x);
                check("out_y", out_y, e.y);
            end
        end
        n_sh   += int'(start_shift);
        n_calc += int'(start_calc);
        n_done += int'(image_done);
        m_rd   += int'(sr_m);
        m_sh   += int'(ss_m);
        m_calc += int'(sc_m);
        m_done += int'(done_m);
        if (sw_m) begin
            m_wr++;
            check("min_out_xy", {ox_m, oy_m}, 0);
        end
    end

    // Responder for the 5x4 instance: optional random delay and a
    // spurious done in the issue cycle.
    initial forever begin
        logic [3:0] p;
        @(posedge clk); #1;
        p = {start_write, start_calc, start_shift, start_read};
        for (int u = 0; u < 4; u++) begin
            if (dn[u]) dn[u] = 1'b0;
            if (cnt[u] == 0) begin
                dn[u]  = 1'b1;
                cnt[u] = -1;
            end else if (cnt[u] > 0) begin
                cnt[u]--;
            end
            if (p[u]) begin
                cnt[u] = rnd ? int'($urandom_range(7, glitch ? 1 : 0)) : 0;
                if (glitch) dn[u] = 1'b1;
            end
        end
    end

    // 1-cycle responder for the minimum instance
    initial forever begin
        @(posedge clk); #1;
        dm      = pm_last;
        pm_last = {sw_m, sc_m, ss_m, sr_m};
    end

    initial begin
        m_rd = 0; m_sh = 0; m_calc = 0; m_wr = 0; m_done = 0;
        clear_counts();
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_pulses", {start_read, start_shift, start_calc,
                             start_write, image_done}, 0);
        check("rst_coords", {rd_x, rd_y, out_x, out_y}, 0);
        @(posedge clk); #1 n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);

        for (int mode = 0; mode < 3; mode++) begin
            rnd    = (mode > 0);
            glitch = (mode == 2);
            @(posedge clk); #1 clear_counts();
            push_image(5, 4);
            run_start();
            wait_image(3000);
            check("reads", n_rd, 30);
            check("shifts", n_sh, 4);
            check("calcs", n_calc, 6);
            check("writes", n_wr, 6);
            check("image_done_count", n_done, 1);
            check("rd_queue_left", exp_rd.size(), 0);
            check("wr_queue_left", exp_wr.size(), 0);
            repeat (10) @(negedge clk);
        end
        rnd = 0;
        glitch = 0;

        // Abort while waiting on calc
        @(posedge clk); #1 clear_counts();
        push_window(0, 0);
        run_start();
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (start_calc) seen = 1;
            end
            check("calc_timeout", seen, 1);
        end
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_no_write", start_write, 0);
        repeat (10) @(negedge clk);
        check("abort_writes", n_wr, 0);
        check("abort_reads", n_rd, 9);
        check("abort_rd_queue", exp_rd.size(), 0);
        @(posedge clk); #1 clear_counts();
        push_image(5, 4);
        run_start();
        wait_image(1000);
        check("restart_reads", n_rd, 30);
        check("restart_rd_queue", exp_rd.size(), 0);

        // Asynchronous reset in LOAD_WAIT
        @(posedge clk); #1 clear_counts();
        push_image(5, 4);
        run_start();
        @(posedge clk); #1 n_rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_pulses", {start_read, start_shift, start_calc,
                                start_write, image_done}, 0);
        check("midrst_coords", {rd_x, rd_y, out_x, out_y}, 0);
        exp_rd.delete();
        exp_wr.delete();
        @(posedge clk); #1 n_rst = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_idle", busy, 0);
        check("midrst_reads", n_rd, 1);

        // Minimum image on the 3x3 instance
        @(posedge clk); #1 start_m = 1'b1;
        @(posedge clk); #1 start_m = 1'b0;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                if (done_m) seen = 1;
            end
            check("min_done_timeout", seen, 1);
        end
        @(negedge clk);
        check("min_busy_after", busy_m, 0);
        check("min_reads", m_rd, 9);
        check("min_shifts", m_sh, 0);
        check("min_calcs", m_calc, 1);
        check("min_writes", m_wr, 1);
        check("min_done_count", m_done, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
